// File: rtl/tap_tempo.sv
// Tap-tempo front end: synchronises and debounces a tap button, averages the last four
// tap intervals into a beat period and generates a free-running beat pulse at that period.
module tap_tempo #(
    parameter int CNT_W      = 24,
    parameter int DEB_CYC    = 16,
    parameter int MIN_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tap,
    input  logic             enable,
    output logic             tap_seen,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             beat
);

    localparam int               DEB_W    = $clog2(DEB_CYC) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t             state;
    logic               tap_s1, tap_s2;
    logic               deb, deb_d;
    logic [DEB_W-1:0]   deb_cnt;
    logic [CNT_W-1:0]   icnt;
    logic [CNT_W-1:0]   phase;
    logic [CNT_W-1:0]   hist [4];
    logic               hist_ok;
    logic               hist_upd;
    logic               tap_evt;
    logic [CNT_W-1:0]   interval;
    logic [CNT_W+1:0]   sum;

    assign tap_evt  = deb & ~deb_d;
    // The counter holds cycles-1 since the last accepted tap; never used when icnt == CNT_MAX.
    assign interval = icnt + 1'b1;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) sum = sum + {2'b00, hist[i]};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tap_s1  <= 1'b0;
            tap_s2  <= 1'b0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            tap_s1 <= tap;
            tap_s2 <= tap_s1;
            deb_d  <= deb;
            if (tap_s2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= tap_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            icnt         <= '0;
            phase        <= '0;
            hist_ok      <= 1'b0;
            hist_upd     <= 1'b0;
            tap_seen     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            beat         <= 1'b0;
            // NOTE: the history is a small register file, cleared explicitly because the sum reads all entries.
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else begin
            tap_seen <= 1'b0;
            beat     <= 1'b0;
            hist_upd <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                icnt    <= '0;
                phase   <= '0;
                hist_ok <= 1'b0;
                for (int i = 0; i < 4; i++) hist[i] <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        icnt <= '0;
                        if (tap_evt) begin
                            tap_seen <= 1'b1;
                            state    <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (icnt == CNT_MAX) begin
                            // Timeout: a coincident tap restarts measurement as a first tap.
                            icnt    <= '0;
                            hist_ok <= 1'b0;
                            for (int i = 0; i < 4; i++) hist[i] <= '0;
                            if (tap_evt) tap_seen <= 1'b1;
                            else         state    <= IDLE;
                        end else if (tap_evt && interval >= MIN_P) begin
                            tap_seen <= 1'b1;
                            hist_upd <= 1'b1;
                            hist_ok  <= 1'b1;
                            icnt     <= '0;
                            if (!hist_ok) begin
                                for (int i = 0; i < 4; i++) hist[i] <= interval;
                            end else begin
                                hist[0] <= interval;
                                for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
                            end
                        end else begin
                            icnt <= icnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // A fresh period resynchronises the beat to the user's tap.
                if (hist_upd) begin
                    period       <= CNT_W'(sum >> 2);
                    period_valid <= 1'b1;
                    phase        <= '0;
                    beat         <= 1'b1;
                end else if (period_valid) begin
                    if (phase == period - 1'b1) begin
                        beat  <= 1'b1;
                        phase <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tap_tempo.sv
// Bench for tap_tempo: table of tap pulses with expected periods, a tap_seen scoreboard,
// and hand-written sequences for beat spacing, timeout, enable gating and reset.
module tb_tap_tempo;

    localparam int CNT_W = 8;
    localparam int DEB   = 4;
    localparam int MINP  = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tap = 1'b0;
    logic             enable = 1'b1;
    logic             tap_seen;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             beat;

    tap_tempo #(.CNT_W(CNT_W), .DEB_CYC(DEB), .MIN_PERIOD(MINP)) dut (
        .clk          (clk),
        .reset        (reset),
        .tap          (tap),
        .enable       (enable),
        .tap_seen     (tap_seen),
        .period       (period),
        .period_valid (period_valid),
        .beat         (beat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    typedef struct {
        int hi;
        int lo;
        bit acc;
        int exp_p;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Scoreboard: each tap_seen pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (tap_seen) begin
            if (exp_q.size() == 0) check("unexpected tap_seen", cyc, -1);
            else                   check("tap_seen cycle", cyc, exp_q.pop_front());
        end
    end

    // One tap pulse: hi cycles high, lo cycles low; the next rise follows hi+lo cycles later.
    task automatic pulse(input int hi, input int lo, input bit acc, input int exp_p, input string nm);
        int c0;
        c0  = cyc;
        tap = 1'b1;
        if (acc) exp_q.push_back(c0 + DEB + 3);
        for (int i = 1; i <= hi + lo; i++) begin
            @(negedge clk);
            if (i == hi) tap = 1'b0;
            if (exp_p >= 0 && i == DEB + 4) begin
                check({nm, " period"}, int'(period), exp_p);
                check({nm, " period_valid"}, int'(period_valid), 1);
                check({nm, " resync beat"}, int'(beat), 1);
            end
        end
        check({nm, " tap_seen outstanding"}, exp_q.size(), 0);
    endtask

    task automatic wait_beat(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (beat) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int beats;

        vecs[0] = '{hi: 10, lo: 90,  acc: 1'b1, exp_p: -1};
        vecs[1] = '{hi: 10, lo: 90,  acc: 1'b1, exp_p: 100};
        vecs[2] = '{hi: 10, lo: 90,  acc: 1'b1, exp_p: 100};
        vecs[3] = '{hi: 10, lo: 110, acc: 1'b1, exp_p: 100};
        vecs[4] = '{hi: 10, lo: 10,  acc: 1'b1, exp_p: 105};
        vecs[5] = '{hi: 3,  lo: 7,   acc: 1'b0, exp_p: -1};
        vecs[6] = '{hi: 5,  lo: 5,   acc: 1'b1, exp_p: -1};
        vecs[7] = '{hi: 5,  lo: 85,  acc: 1'b0, exp_p: -1};
        vecs[8] = '{hi: 10, lo: 10,  acc: 1'b1, exp_p: 100};
        vecs[9] = '{hi: 10, lo: 300, acc: 1'b1, exp_p: 80};

        reset = 1'b0;
        tap   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset tap_seen", int'(tap_seen), 0);
        check("reset period", int'(period), 0);
        check("reset period_valid", int'(period_valid), 0);
        check("reset beat", int'(beat), 0);
        reset = 1'b1;
        tap   = 1'b0;
        repeat (20) @(negedge clk);
        check("post-reset period_valid", int'(period_valid), 0);

        for (int i = 0; i <= 4; i++)
            pulse(vecs[i].hi, vecs[i].lo, vecs[i].acc, vecs[i].exp_p, $sformatf("vec%0d", i));

        wait_beat(200, n);
        check("first free-running beat gap", n, 93);
        wait_beat(200, n);
        check("beat spacing", n, 105);

        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("period held while disabled", int'(period), 105);
        enable = 1'b1;

        for (int i = 5; i <= 9; i++)
            pulse(vecs[i].hi, vecs[i].lo, vecs[i].acc, vecs[i].exp_p, $sformatf("vec%0d", i));

        check("period after timeout", int'(period), 80);
        check("period_valid after timeout", int'(period_valid), 1);
        pulse(10, 50, 1'b1, -1, "first tap after timeout");
        check("no period change on first tap", int'(period), 80);
        pulse(10, 10, 1'b1, 60, "second tap after timeout");

        enable = 1'b0;
        pulse(10, 30, 1'b0, -1, "tap while disabled");
        beats = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (beat) beats++;
        end
        check("beats while disabled", beats, 0);
        check("period held while disabled", int'(period), 60);
        check("period_valid held while disabled", int'(period_valid), 1);
        enable = 1'b1;
        wait_beat(200, n);
        check("beat gap after enable", n, 60);

        pulse(10, 30, 1'b1, -1, "tap before reset");
        reset = 1'b0;
        @(negedge clk);
        check("mid-run reset period_valid", int'(period_valid), 0);
        check("mid-run reset period", int'(period), 0);
        check("mid-run reset beat", int'(beat), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("final scoreboard empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
